ula_seq: RTL and testbench
==========================

# ula_seq

Parametrised sequential successor to the combinational ALU datapath. It takes one operation at a time through a valid/ready handshake. Single-cycle ops return a registered result one cycle after acceptance. A new signed iterative multiply (MUL) takes WIDTH+1 cycles. It adds the signed-overflow and illegal-op flags the single-cycle ALU lacks, and sits between the ALU-control decode and the register write-back stage.

## Interface
- WIDTH, default 32: operand/result width; power of two, ≥ 8.
- SHW, default $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  4  operation code (package encoding).
- in_a  in  WIDTH  operand A, signed two's complement.
- in_b  in  WIDTH  operand B, signed two's complement.
- in_shamt  in  SHW  shift amount for SLL/SRL/SRA.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  WIDTH  result.
- out_ovf  out  1  signed overflow (ADD, SUB, MUL only; 0 otherwise).
- out_illegal  out  1  in_op is not a defined code.
- busy  out  1  FSM not in IDLE.

## Operation
- Op codes: ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, SRA=6, SLT=7, MUL=8. Codes 9–15 are illegal.
- Accept when in_valid && in_ready. Operands and op are captured on that edge; inputs are don't-care afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Only one op is in flight at a time.
- ADD/SUB: modulo 2^WIDTH.
  - ADD ovf = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB ovf = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
- SLL/SRL are logical shifts by in_shamt. SRA is arithmetic (sign-filling).
- SLT: signed compare; result 1 if a<b, else 0, zero-extended.
- MUL: signed, low WIDTH bits of the 2·WIDTH product.
  - Operands are converted to magnitudes. Unsigned shift-add runs one bit per cycle. The sign is applied in the final cycle.
  - ovf = 1 when the full product does not sign-extend from bit WIDTH-1.
- Illegal op: result 0, ovf 0, illegal 1. Latency is the same as single-cycle ops.
- FSM states:
  - IDLE: on accept, MUL goes to MRUN (counter=0). Any other op loads the output register and stays in IDLE.
  - MRUN: one partial-product step per cycle. When counter==WIDTH-1, go to MFIN.
  - MFIN: sign correction and overflow computed; output register loaded; out_valid set; go to IDLE.
- Output register holds result and flags stable while out_valid && !out_ready. It clears out_valid on out_ready unless it is reloaded on the same edge.

## Timing
- Reset (async assert, sync deassert at the integrating level): state=IDLE, out_valid=0, out_result=0, out_ovf=0, out_illegal=0, busy=0, counter=0. in_ready=1 in the first cycle after reset release.
- Single-cycle ops: accept at edge k → out_valid high after edge k+1.
- MUL: accept at edge k → MRUN covers edges k+1..k+WIDTH → MFIN load at edge k+WIDTH+1. Latency is WIDTH+1 (33 for WIDTH=32).
- in_ready is low throughout MRUN/MFIN. busy is high throughout MRUN/MFIN.
- Simultaneous out_ready and a new accept on the same edge: the old result is consumed and the new single-cycle result is loaded. out_valid stays 1 with no bubble.
- Reset mid-MUL: the op is abandoned. No result is emitted after release.

## Structure
- Package ula_pkg holds:
  - op-code localparams/enum (ADD..MUL)
  - FSM state enum (IDLE, MRUN, MFIN)
  - an is_legal_op function
- One sub-module, ula_mul_iter: magnitude shift-add datapath, counter, and sign/overflow fix-up. It is driven by start/step/fin from the ula_seq FSM.
- Single-cycle ops stay as combinational logic inside ula_seq, feeding the output register.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, ovf=1, out_valid exactly 1 cycle after accept; SUB 0x80000000 − 1 → 0x7FFFFFFF, ovf=1.
- SRA 0x80000000 shamt=4 → 0xF8000000; SRL same → 0x08000000; SLT −1 vs 1 → 0x00000001.
- MUL −3 × 7 → 0xFFFFFFEB, ovf=0, out_valid 33 cycles after accept, in_ready=0 and busy=1 throughout; MUL 0x00010000 × 0x00010000 → 0x00000000, ovf=1.
- Back-pressure: ADD 5+6 with out_ready=0 for 10 cycles → result 0x0000000B held stable, in_ready=0; release out_ready with a new in_valid on the same cycle → back-to-back results, no bubble.
- Reset asserted 10 cycles into a MUL → all outputs at reset values immediately, in_ready=1 after release, no stray out_valid.
- in_op=4'hF → result 0, out_illegal=1, ovf=0, 1-cycle latency.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and op legality.
package ula_pkg;

    // Operation codes presented on in_op; 9..15 are undefined.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_SLT = 4'd7,
        OP_MUL = 4'd8
    } op_e;

    // Control FSM: IDLE handles single-cycle ops, MRUN/MFIN sequence the multiplier.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MRUN = 2'd1,
        ST_MFIN = 2'd2
    } state_e;

    // True for codes that name a defined operation.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative signed multiplier: magnitudes are multiplied by unsigned shift-add,
// one multiplier bit per step, and the sign is re-applied at the end.
module ula_mul_iter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             fin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_step,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a_s = a;
        mag_b_s = b;
        if (a[WIDTH-1]) begin
            mag_a_s = ~a + WIDTH'(1);
        end else begin
            mag_a_s = a;
        end
        if (b[WIDTH-1]) begin
            mag_b_s = ~b + WIDTH'(1);
        end else begin
            mag_b_s = b;
        end
    end

    // Datapath next state: load on start, one partial product per step, clear counter on fin.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, mag_a_s};
            mplier_d = mag_b_s;
            neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d    = {SHW{1'b0}};
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
        end else if (fin) begin
            cnt_d = {SHW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            cnt_q    <= {SHW{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    // Sign fix-up and overflow: the product must sign-extend from bit WIDTH-1.
    always_comb begin
        prod_s = acc_q;
        if (neg_q) begin
            prod_s = ~acc_q + (2*WIDTH)'(1);
        end else begin
            prod_s = acc_q;
        end
        res       = prod_s[WIDTH-1:0];
        ovf       = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        last_step = (cnt_q == SHW'(WIDTH-1));
    end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle ops plus an iterative signed multiply behind a
// valid/ready handshake, with registered result, overflow and illegal-op flags.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_illegal_q, out_illegal_d;

    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;

    logic             mul_start_s;
    logic             mul_step_s;
    logic             mul_fin_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] mul_res_s;
    logic             mul_ovf_s;

    assign in_ready_s  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign in_ready    = in_ready_s;
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_ovf     = out_ovf_q;
    assign out_illegal = out_illegal_q;

    // Single-cycle result and overflow; MUL and undefined codes produce zero here.
    always_comb begin
        sum_s     = in_a + in_b;
        diff_s    = in_a - in_b;
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_s[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = in_a & in_b;
            OP_OR:   alu_res_s = in_a | in_b;
            OP_SLL:  alu_res_s = in_a << in_shamt;
            OP_SRL:  alu_res_s = in_a >> in_shamt;
            OP_SRA:  alu_res_s = WIDTH'($signed(in_a) >>> in_shamt);
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // FSM next state, multiplier sequencing and output-register load/drain.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        out_ovf_d     = out_ovf_q;
        out_illegal_d = out_illegal_q;
        mul_start_s   = 1'b0;
        mul_step_s    = 1'b0;
        mul_fin_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (in_op == OP_MUL) begin
                        mul_start_s = 1'b1;
                        state_d     = ST_MRUN;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_result_d  = alu_res_s;
                        out_ovf_d     = alu_ovf_s;
                        out_illegal_d = !is_legal_op(in_op);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MRUN: begin
                mul_step_s = 1'b1;
                if (mul_last_s) begin
                    state_d = ST_MFIN;
                end else begin
                    state_d = ST_MRUN;
                end
            end
            ST_MFIN: begin
                mul_fin_s     = 1'b1;
                out_valid_d   = 1'b1;
                out_result_d  = mul_res_s;
                out_ovf_d     = mul_ovf_s;
                out_illegal_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= {WIDTH{1'b0}};
            out_ovf_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_ovf_q     <= out_ovf_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    ula_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start_s),
        .step      (mul_step_s),
        .fin       (mul_fin_s),
        .a         (in_a),
        .b         (in_b),
        .last_step (mul_last_s),
        .res       (mul_res_s),
        .ovf       (mul_ovf_s)
    );

endmodule

// File: tb/tb_ula_seq.sv
// Directed-vector bench for ula_seq at WIDTH=32.
module tb_ula_seq;
    import ula_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = 4'd0;
    logic [WIDTH-1:0] in_a = 32'd0;
    logic [WIDTH-1:0] in_b = 32'd0;
    logic [SHW-1:0]   in_shamt = 5'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic             out_illegal;
    logic             busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_shamt    (in_shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge, wait (bounded) for acceptance, then scramble inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        int n = 0;
        in_op = op; in_a = a; in_b = b; in_shamt = sh; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) check_val("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 4'd3; in_a = 32'hDEADBEEF; in_b = 32'h12345678; in_shamt = 5'd17;
    endtask

    // Single-cycle op: result must be valid in the cycle right after acceptance.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                          input logic eo, input logic ei);
        issue(op, a, b, sh);
        @(negedge clk);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_res"}, 64'(out_result), 64'(er));
        check_val({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        check_val({tag, "_ill"}, 64'(out_illegal), 64'(ei));
    endtask

    // MUL: busy/!in_ready until the load edge, which is WIDTH+1 edges after accept.
    task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eo);
        int cyc = 0;
        bit hold_ok = 1'b1;
        issue(OP_MUL, a, b, 5'd0);
        @(negedge clk);
        while (!out_valid && cyc < 60) begin
            if (!busy || in_ready) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_lat"}, 64'(cyc), 64'd33);
        check_val({tag, "_busy"}, 64'(hold_ok), 64'd1);
        check_val({tag, "_res"}, 64'(out_result), 64'(er));
        check_val({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        check_val({tag, "_ill"}, 64'(out_illegal), 64'd0);
        check_val({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit ok;
        // Reset
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_res", 64'(out_result), 64'd0);
        check_val("rst_ovf", 64'(out_ovf), 64'd0);
        check_val("rst_ill", 64'(out_illegal), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("rst_ready", 64'(in_ready), 64'd1);

        // Single-cycle vectors
        single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0);
        single("sub_ovf", OP_SUB, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        single("add_neg", OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0);
        single("sra", OP_SRA, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 1'b0, 1'b0);
        single("srl", OP_SRL, 32'h80000000, 32'h0, 5'd4, 32'h08000000, 1'b0, 1'b0);
        single("sll", OP_SLL, 32'h00000001, 32'h0, 5'd31, 32'h80000000, 1'b0, 1'b0);
        single("slt_t", OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
        single("slt_f", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b0, 1'b0);
        single("and", OP_AND, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 1'b0, 1'b0);
        single("or", OP_OR, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 1'b0, 1'b0);
        single("illegal", 4'hF, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h00000000, 1'b0, 1'b1);
        single("illegal9", 4'h9, 32'h12345678, 32'h1, 5'd0, 32'h00000000, 1'b0, 1'b1);

        // Multiplies
        mul_op("mul_m3x7", 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0);
        mul_op("mul_big", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        mul_op("mul_minxm1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        mul_op("mul_m5xm6", 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 1'b0);

        // Back-pressure then same-edge consume + accept
        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_ADD, 32'd5, 32'd6, 5'd0);
        @(negedge clk);
        ok = 1'b1;
        repeat (10) begin
            if (!out_valid || out_result !== 32'h0000000B || in_ready) ok = 1'b0;
            @(negedge clk);
        end
        check_val("bp_hold", 64'(ok), 64'd1);
        check_val("bp_res", 64'(out_result), 64'h0000000B);
        out_ready = 1'b1;
        in_op = OP_SUB; in_a = 32'd20; in_b = 32'd3; in_shamt = 5'd0; in_valid = 1'b1;
        #1;
        check_val("bp_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("b2b_valid", 64'(out_valid), 64'd1);
        check_val("b2b_res", 64'(out_result), 64'h00000011);
        @(negedge clk);

        // Reset in the middle of a multiply
        issue(OP_MUL, 32'hFFFFFFFD, 32'h00000007, 5'd0);
        repeat (10) @(negedge clk);
        check_val("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", 64'(out_valid), 64'd0);
        check_val("mrst_res", 64'(out_result), 64'd0);
        check_val("mrst_busy", 64'(busy), 64'd0);
        check_val("mrst_ovf", 64'(out_ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("mrst_ready", 64'(in_ready), 64'd1);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) ok = 1'b0;
        end
        check_val("mrst_quiet", 64'(ok), 64'd1);

        // Function after reset
        single("post_add", OP_ADD, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
